// File: rtl/median_window_writer.sv
// Sample ring writer and sliding-window reader for a median filter.
// Each accepted sample is written to an external ring RAM; once WIN_LEN samples exist, the newest window is streamed out oldest first.
module median_window_writer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int WIN_LEN    = 5,
  parameter int RD_LAT     = 0
) (
  input  logic                  wr_clk,
  input  logic                  asyn_rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  flush,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic                  w_last,
  output logic [ADDR_WIDTH:0]   fill_cnt
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   WIN_CNT  = (ADDR_WIDTH+1)'(WIN_LEN);
  // WIN_LEN may equal the ring depth, in which case the base offset is zero.
  localparam logic [ADDR_WIDTH-1:0] WIN_OFS  = ADDR_WIDTH'(WIN_LEN % DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WIN_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_rd_idx;
  logic [ADDR_WIDTH:0]   r_fill;
  logic                  r_valid;

  logic                  w_accept;
  logic                  w_beat;
  logic                  w_is_last;
  logic [ADDR_WIDTH:0]   w_fill_inc;

  assign s_ready    = (r_state == IDLE) & ~flush;
  assign w_accept   = s_valid & s_ready;
  assign w_beat     = r_valid & w_ready;
  assign w_is_last  = (r_rd_idx == LAST_IDX);
  assign w_fill_inc = (r_fill == WIN_CNT) ? r_fill : r_fill + 1'b1;

  assign ram_wr_en   = w_accept;
  assign ram_wr_addr = r_wptr;
  assign ram_wr_data = s_data;

  // Modular arithmetic handles ring wrap; wptr already points past the newest sample.
  assign ram_rd_addr = r_wptr - WIN_OFS + r_rd_idx;

  assign w_data   = ram_rd_data;
  assign w_valid  = r_valid;
  assign w_last   = r_valid & w_is_last;
  assign fill_cnt = r_fill;

  always_ff @(posedge wr_clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      r_state  <= IDLE;
      r_wptr   <= '0;
      r_rd_idx <= '0;
      r_fill   <= '0;
      r_valid  <= 1'b0;
    end else if (flush) begin
      r_state  <= IDLE;
      r_rd_idx <= '0;
      r_fill   <= '0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_wptr <= r_wptr + 1'b1;
            r_fill <= w_fill_inc;
            if (w_fill_inc == WIN_CNT) begin
              if (RD_LAT != 0) begin
                r_state <= RD_ADDR;
              end else begin
                r_state <= RD_DATA;
                r_valid <= 1'b1;
              end
            end
          end
        end
        RD_ADDR: begin
          // Registered RAM needs one cycle with the address presented.
          r_state <= RD_DATA;
          r_valid <= 1'b1;
        end
        RD_DATA: begin
          if (w_beat) begin
            if (w_is_last) begin
              r_rd_idx <= '0;
              r_state  <= IDLE;
              r_valid  <= 1'b0;
            end else begin
              r_rd_idx <= r_rd_idx + 1'b1;
              if (RD_LAT != 0) begin
                r_state <= RD_ADDR;
                r_valid <= 1'b0;
              end
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_median_window_writer.sv
// Directed bench: an unregistered-RAM instance and a registered-RAM instance, each with a behavioural ring RAM.
module tb_median_window_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: RD_LAT=0
  logic        rst0, s_valid0, s_ready0, flush0, wr_en0, w_valid0, w_ready0, w_last0;
  logic [15:0] s_data0, wr_data0, rd_data0, w_data0;
  logic [3:0]  wr_addr0, rd_addr0;
  logic [4:0]  fill0;
  logic [15:0] mem0 [16];

  median_window_writer #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .WIN_LEN(5), .RD_LAT(0)) dut0 (
    .wr_clk(clk), .asyn_rst(rst0), .s_data(s_data0), .s_valid(s_valid0), .s_ready(s_ready0),
    .flush(flush0), .ram_wr_en(wr_en0), .ram_wr_addr(wr_addr0), .ram_wr_data(wr_data0),
    .ram_rd_addr(rd_addr0), .ram_rd_data(rd_data0), .w_data(w_data0), .w_valid(w_valid0),
    .w_ready(w_ready0), .w_last(w_last0), .fill_cnt(fill0)
  );
  always @(posedge clk) if (wr_en0) mem0[wr_addr0] <= wr_data0;
  assign rd_data0 = mem0[rd_addr0];

  // Instance 1: RD_LAT=1 with registered read
  logic        rst1, s_valid1, s_ready1, flush1, wr_en1, w_valid1, w_ready1, w_last1;
  logic [15:0] s_data1, wr_data1, rd_data1, w_data1;
  logic [3:0]  wr_addr1, rd_addr1;
  logic [4:0]  fill1;
  logic [15:0] mem1 [16];

  median_window_writer #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .WIN_LEN(5), .RD_LAT(1)) dut1 (
    .wr_clk(clk), .asyn_rst(rst1), .s_data(s_data1), .s_valid(s_valid1), .s_ready(s_ready1),
    .flush(flush1), .ram_wr_en(wr_en1), .ram_wr_addr(wr_addr1), .ram_wr_data(wr_data1),
    .ram_rd_addr(rd_addr1), .ram_rd_data(rd_data1), .w_data(w_data1), .w_valid(w_valid1),
    .w_ready(w_ready1), .w_last(w_last1), .fill_cnt(fill1)
  );
  always @(posedge clk) begin
    if (wr_en1) mem1[wr_addr1] <= wr_data1;
    rd_data1 <= mem1[rd_addr1];
  end

  logic [3:0] exp_wptr0;
  int         exp_fill0;
  int         last_acc0;

  task automatic do_reset0();
    rst0 = 1'b1; s_valid0 = 1'b0; flush0 = 1'b0; w_ready0 = 1'b1; s_data0 = '0;
    @(negedge clk); #1;
    rst0 = 1'b0; exp_wptr0 = '0; exp_fill0 = 0; #1;
  endtask

  task automatic push0(input logic [15:0] v);
    int t;
    t = 0;
    s_valid0 = 1'b1; s_data0 = v; #1;
    while (s_ready0 !== 1'b1 && t < 20) begin
      @(negedge clk); #1; t++;
    end
    vectors++;
    if (wr_en0 !== 1'b1 || wr_addr0 !== exp_wptr0 || wr_data0 !== v) begin
      miscompares++;
      $display("FAIL push sample=%0d: wr_en=%b addr=%0d data=%0d, required wr_en=1 addr=%0d data=%0d",
               v, wr_en0, wr_addr0, wr_data0, exp_wptr0, v);
    end
    last_acc0 = cyc;
    exp_wptr0 = exp_wptr0 + 4'd1;
    if (exp_fill0 < 5) exp_fill0++;
    @(negedge clk); #1;
    s_valid0 = 1'b0; #1;
    vectors++;
    if (fill0 !== 5'(exp_fill0) || w_valid0 !== (exp_fill0 == 5)) begin
      miscompares++;
      $display("FAIL post_push sample=%0d: fill_cnt=%0d w_valid=%b, required fill_cnt=%0d w_valid=%b",
               v, fill0, w_valid0, exp_fill0, (exp_fill0 == 5));
    end
  endtask

  // Window of consecutive values first..first+4 stored at consecutive ring addresses a0..a0+4.
  task automatic collect0(input logic [15:0] first, input logic [3:0] a0, input int stall_at, input int stall_n);
    for (int i = 0; i < 5; i++) begin
      int t;
      logic [15:0] ev;
      logic [3:0]  ea;
      t = 0;
      ev = first + 16'(i);
      ea = a0 + 4'(i);
      while (w_valid0 !== 1'b1 && t < 8) begin
        @(negedge clk); #1; t++;
      end
      if (i == stall_at) begin
        for (int k = 0; k < stall_n; k++) begin
          w_ready0 = 1'b0; #1;
          vectors++;
          if (w_valid0 !== 1'b1 || w_data0 !== ev || rd_addr0 !== ea || w_last0 !== (i == 4)) begin
            miscompares++;
            $display("FAIL stall beat=%0d cyc=%0d: valid=%b data=%0d addr=%0d last=%b, required valid=1 data=%0d addr=%0d",
                     i, k, w_valid0, w_data0, rd_addr0, w_last0, ev, ea);
          end
          @(negedge clk); #1;
        end
      end
      w_ready0 = 1'b1; #1;
      vectors++;
      if (w_valid0 !== 1'b1 || w_data0 !== ev || w_last0 !== (i == 4) || rd_addr0 !== ea ||
          s_ready0 !== 1'b0 || wr_en0 !== 1'b0) begin
        miscompares++;
        $display("FAIL beat %0d of window %0d: valid=%b data=%0d last=%b addr=%0d s_ready=%b wr_en=%b, required valid=1 data=%0d last=%b addr=%0d s_ready=0 wr_en=0",
                 i, first, w_valid0, w_data0, w_last0, rd_addr0, s_ready0, wr_en0, ev, (i == 4), ea);
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1;
    s_valid0 = 1'b0; s_data0 = '0; flush0 = 1'b0; w_ready0 = 1'b1;
    s_valid1 = 1'b0; s_data1 = '0; flush1 = 1'b0; w_ready1 = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if (w_valid0 !== 1'b0 || w_last0 !== 1'b0 || fill0 !== 5'd0 || wr_en0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: w_valid=%b w_last=%b fill_cnt=%0d wr_en=%b, required all 0",
               w_valid0, w_last0, fill0, wr_en0);
    end
    rst0 = 1'b0; rst1 = 1'b0; #1;
    vectors++;
    if (s_ready0 !== 1'b1 || s_ready1 !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: s_ready0=%b s_ready1=%b, required 1 1", s_ready0, s_ready1);
    end
    exp_wptr0 = '0; exp_fill0 = 0;
  endtask

  task automatic test_first_window();
    for (int v = 1; v <= 5; v++) push0(16'(v));
    collect0(16'd1, 4'd0, -1, 0);
    vectors++;
    if (s_ready0 !== 1'b1 || w_valid0 !== 1'b0) begin
      miscompares++;
      $display("FAIL window_end: s_ready=%b w_valid=%b, required 1 0", s_ready0, w_valid0);
    end
  endtask

  task automatic test_slide();
    push0(16'd6);
    collect0(16'd2, 4'd1, -1, 0);
  endtask

  task automatic test_wrap();
    for (int v = 7; v <= 19; v++) begin
      push0(16'(v));
      collect0(16'(v - 4), 4'(v - 5), -1, 0);
    end
    push0(16'd20);
    collect0(16'd16, 4'd15, -1, 0);
  endtask

  task automatic test_back_to_back();
    int prev;
    push0(16'd21);
    prev = last_acc0;
    s_valid0 = 1'b1; s_data0 = 16'd22;
    collect0(16'd17, 4'd0, -1, 0);
    push0(16'd22);
    vectors++;
    if (last_acc0 - prev !== 6) begin
      miscompares++;
      $display("FAIL sample_period: %0d cycles, required 6", last_acc0 - prev);
    end
    collect0(16'd18, 4'd1, -1, 0);
  endtask

  task automatic test_backpressure();
    do_reset0();
    for (int v = 1; v <= 5; v++) push0(16'(v));
    collect0(16'd1, 4'd0, 1, 3);
  endtask

  task automatic test_flush();
    do_reset0();
    for (int v = 1; v <= 5; v++) push0(16'(v));
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (w_valid0 !== 1'b1 || w_data0 !== 16'(i + 1)) begin
        miscompares++;
        $display("FAIL pre_flush beat %0d: valid=%b data=%0d, required 1 %0d", i, w_valid0, w_data0, i + 1);
      end
      @(negedge clk); #1;
    end
    flush0 = 1'b1; s_valid0 = 1'b1; s_data0 = 16'd99; #1;
    vectors++;
    if (s_ready0 !== 1'b0 || wr_en0 !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_cycle: s_ready=%b wr_en=%b, required 0 0", s_ready0, wr_en0);
    end
    @(negedge clk); #1;
    flush0 = 1'b0; s_valid0 = 1'b0; #1;
    vectors++;
    if (w_valid0 !== 1'b0 || w_last0 !== 1'b0 || fill0 !== 5'd0) begin
      miscompares++;
      $display("FAIL after_flush: w_valid=%b w_last=%b fill_cnt=%0d, required 0 0 0", w_valid0, w_last0, fill0);
    end
    exp_fill0 = 0;
    for (int v = 7; v <= 10; v++) push0(16'(v));
    push0(16'd11);
    collect0(16'd7, 4'd5, -1, 0);
  endtask

  task automatic test_rdlat1();
    for (int v = 1; v <= 6; v++) begin
      s_valid1 = 1'b1; s_data1 = 16'(v); #1;
      vectors++;
      if (s_ready1 !== 1'b1 || wr_en1 !== 1'b1 || wr_addr1 !== 4'(v - 1)) begin
        miscompares++;
        $display("FAIL lat1_push %0d: s_ready=%b wr_en=%b addr=%0d, required 1 1 %0d", v, s_ready1, wr_en1, wr_addr1, v - 1);
      end
      @(negedge clk); #1;
      s_valid1 = 1'b0; #1;
      if (v == 5) begin
        for (int i = 0; i < 5; i++) begin
          vectors++;
          if (w_valid1 !== 1'b0 || rd_addr1 !== 4'(i)) begin
            miscompares++;
            $display("FAIL lat1_addr_phase %0d: valid=%b addr=%0d, required 0 %0d", i, w_valid1, rd_addr1, i);
          end
          @(negedge clk); #1;
          vectors++;
          if (w_valid1 !== 1'b1 || w_data1 !== 16'(i + 1) || w_last1 !== (i == 4)) begin
            miscompares++;
            $display("FAIL lat1_beat %0d: valid=%b data=%0d last=%b, required 1 %0d %b", i, w_valid1, w_data1, w_last1, i + 1, (i == 4));
          end
          @(negedge clk); #1;
        end
      end
    end
    // Window 2..6 in flight: address phase, then first data beat, then reset.
    @(negedge clk); #1;
    vectors++;
    if (w_valid1 !== 1'b1 || w_data1 !== 16'd2) begin
      miscompares++;
      $display("FAIL lat1_pre_reset: valid=%b data=%0d, required 1 2", w_valid1, w_data1);
    end
    rst1 = 1'b1; #1;
    vectors++;
    if (w_valid1 !== 1'b0 || w_last1 !== 1'b0 || fill1 !== 5'd0) begin
      miscompares++;
      $display("FAIL lat1_async_reset: valid=%b last=%b fill_cnt=%0d, required 0 0 0", w_valid1, w_last1, fill1);
    end
    @(negedge clk); #1;
    rst1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      vectors++;
      if (w_valid1 !== 1'b0 || s_ready1 !== 1'b1) begin
        miscompares++;
        $display("FAIL lat1_after_reset %0d: valid=%b s_ready=%b, required 0 1", k, w_valid1, s_ready1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_slide();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_rdlat1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
